// File: rtl/mux_pipe_pkg.sv
// Shared definitions for registered pipeline-stage selectors.
// entry_t is the default-width entry record other stage blocks reuse.
package mux_pipe_pkg;
  localparam int          MAX_N_IN      = 16;
  localparam logic [31:0] DEF_RESET_VAL = 32'h0;
  localparam int          ENTRY_DATA_W  = 32;
  localparam int          ENTRY_SEL_W   = 4;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_SEL_W-1:0]  sel;
    logic                    err;
    logic                    valid;
  } entry_t;
endpackage

// File: rtl/mux_n.sv
// Combinational N:1 channel selector; flags indices at or beyond N_IN.
module mux_n
  import mux_pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 N_IN      = 2,
  parameter int                 SEL_W     = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(DEF_RESET_VAL)
) (
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      data,
  output logic                   err
);
  // Loop compare keeps the part-select in range for any sel value.
  always_comb begin
    data = RESET_VAL;
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data = in_data[k*DATA_W +: DATA_W];
        err  = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux_pipe_reg.sv
// Registered N:1 selector stage with valid/ready, 2-entry skid buffer,
// synchronous flush and out-of-range select flagging.
module mux_pipe_reg
  import mux_pipe_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 N_IN      = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(DEF_RESET_VAL),
  localparam int                SEL_W     = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);
  if (N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("mux_pipe_reg: N_IN out of range");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              err;
  } slot_t;

  slot_t             main_q, skid_q, new_e;
  logic              main_v, skid_v;
  logic [DATA_W-1:0] sel_data;
  logic              sel_err;
  logic              push, pop;

  mux_n #(
    .DATA_W   (DATA_W),
    .N_IN     (N_IN),
    .SEL_W    (SEL_W),
    .RESET_VAL(RESET_VAL)
  ) u_mux (
    .in_data(in_data),
    .sel    (sel),
    .data   (sel_data),
    .err    (sel_err)
  );

  assign new_e = '{data: sel_data, sel: sel, err: sel_err};
  assign push  = in_valid & in_ready;
  assign pop   = main_v & out_ready;

  // Skid is only ever filled while main is held, so skid_v implies main_v
  // and in_ready low, which rules out a push when skid drains into main.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '{data: RESET_VAL, sel: '0, err: 1'b0};
      skid_q <= '{data: RESET_VAL, sel: '0, err: 1'b0};
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (push) begin
        main_q <= new_e;
      end else begin
        main_v <= 1'b0;
      end
    end else if (!main_v) begin
      if (push) begin
        main_q <= new_e;
        main_v <= 1'b1;
      end
    end else if (push) begin
      skid_q <= new_e;
      skid_v <= 1'b1;
    end
  end

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q.data;
  assign out_sel   = main_q.sel;
  assign out_err   = main_q.err;
endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: directed scenarios on a 4-input and a 3-input
// instance, then a randomized ready/valid run against a queue model.
module tb_mux_pipe_reg;
  localparam logic [31:0] RV4 = 32'hDEAD_BEEF;
  localparam logic [31:0] RV3 = 32'h0BAD_0000;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  logic [127:0] a_in_data;
  logic [1:0]   a_sel, a_out_sel;
  logic         a_in_valid, a_in_ready, a_flush, a_out_err, a_out_valid, a_out_ready;
  logic [31:0]  a_out_data;

  logic [95:0]  b_in_data;
  logic [1:0]   b_sel, b_out_sel;
  logic         b_in_valid, b_in_ready, b_flush, b_out_err, b_out_valid, b_out_ready;
  logic [31:0]  b_out_data;

  always #5 clk = ~clk;

  mux_pipe_reg #(.DATA_W(32), .N_IN(4), .RESET_VAL(RV4)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data), .out_sel(a_out_sel),
    .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_pipe_reg #(.DATA_W(32), .N_IN(3), .RESET_VAL(RV3)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    nvec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== RV4 ||
                a_out_sel !== 2'd0 || a_out_err !== 1'b0) begin
      nerr++; $display("FAIL reset_init: v=%b r=%b d=%h s=%0d e=%b want v=0 r=1 d=%h s=0 e=0",
                       a_out_valid, a_in_ready, a_out_data, a_out_sel, a_out_err, RV4);
    end
    nvec++; if (b_out_valid !== 1'b0 || b_out_data !== RV3 || b_in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_init_b: v=%b d=%h r=%b want v=0 d=%h r=1",
                       b_out_valid, b_out_data, b_in_ready, RV3);
    end
    rst = 1'b0;
    a_out_ready = 1'b0; a_sel = 2'd0; a_in_valid = 1'b1;
    a_in_data = {96'h0, 32'h1111_1111};
    tick();
    a_in_data = {96'h0, 32'h2222_2222};
    tick();
    a_in_valid = 1'b0;
    nvec++; if (a_in_ready !== 1'b0 || a_out_data !== 32'h1111_1111) begin
      nerr++; $display("FAIL reset_fill: r=%b d=%h want r=0 d=11111111", a_in_ready, a_out_data);
    end
    #3 rst = 1'b1;
    #1;
    nvec++; if (a_out_valid !== 1'b0 || a_out_data !== RV4 || a_in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_mid: v=%b d=%h r=%b want v=0 d=%h r=1",
                       a_out_valid, a_out_data, a_in_ready, RV4);
    end
    tick();
    rst = 1'b0;
    tick();
    nvec++; if (a_out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_release: v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) a_in_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i); a_in_valid = 1'b1;
      want = 32'h1000_0000 + 32'(i);
      tick();
      nvec++; if (a_out_valid !== 1'b1 || a_out_data !== want || a_out_sel !== 2'(i) ||
                  a_in_ready !== 1'b1) begin
        nerr++; $display("FAIL stream_%0d: v=%b d=%h s=%0d r=%b want v=1 d=%h s=%0d r=1",
                         i, a_out_valid, a_out_data, a_out_sel, a_in_ready, want, i);
      end
    end
    a_in_valid = 1'b0;
    tick();
    nvec++; if (a_out_valid !== 1'b0) begin
      nerr++; $display("FAIL stream_drain: v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] want [6];
    logic        wr   [6];
    logic        wv   [6];
    want = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'hC};
    wr   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    a_sel = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) a_in_data[31:0] = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
      if (i == 3) a_out_ready = 1'b1;
      if (i == 5) a_in_valid = 1'b0;
      tick();
      nvec++; if (a_out_valid !== wv[i] || (wv[i] && a_out_data !== want[i]) ||
                  a_in_ready !== wr[i]) begin
        nerr++; $display("FAIL stall_%0d: v=%b d=%h r=%b want v=%b d=%h r=%b",
                         i, a_out_valid, a_out_data, a_in_ready, wv[i], want[i], wr[i]);
      end
    end
  endtask

  task automatic test_bad_sel();
    b_in_data = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_sel = 2'd3;
    tick();
    nvec++; if (b_out_valid !== 1'b1 || b_out_err !== 1'b1 || b_out_sel !== 2'd3 ||
                b_out_data !== RV3) begin
      nerr++; $display("FAIL badsel_oob: v=%b e=%b s=%0d d=%h want v=1 e=1 s=3 d=%h",
                       b_out_valid, b_out_err, b_out_sel, b_out_data, RV3);
    end
    b_sel = 2'd1;
    tick();
    nvec++; if (b_out_err !== 1'b0 || b_out_sel !== 2'd1 || b_out_data !== 32'hC1C1_C1C1) begin
      nerr++; $display("FAIL badsel_ok: e=%b s=%0d d=%h want e=0 s=1 d=c1c1c1c1",
                       b_out_err, b_out_sel, b_out_data);
    end
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    a_sel = 2'd0; a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data[31:0] = 32'h5555_0001;
    tick();
    a_in_data[31:0] = 32'h5555_0002;
    tick();
    nvec++; if (a_in_ready !== 1'b0 || a_out_data !== 32'h5555_0001) begin
      nerr++; $display("FAIL flush_full: r=%b d=%h want r=0 d=55550001", a_in_ready, a_out_data);
    end
    a_in_data[31:0] = 32'h5555_0003;
    a_flush = 1'b1; a_out_ready = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    nvec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 32'h5555_0001) begin
      nerr++; $display("FAIL flush_hit: v=%b r=%b d=%h want v=0 r=1 d=55550001",
                       a_out_valid, a_in_ready, a_out_data);
    end
    tick();
    nvec++; if (a_out_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_after: v=%b want 0", a_out_valid);
    end
    a_in_data[31:0] = 32'h5555_0004; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    nvec++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h5555_0004) begin
      nerr++; $display("FAIL flush_resume: v=%b d=%h want v=1 d=55550004", a_out_valid, a_out_data);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   pops = 0;
    int   cyc  = 0;
    logic do_push, do_pop;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0;
    tick();
    while (pops < 10000 && cyc < 40000) begin
      nvec++; if (b_out_valid !== (q.size() > 0) || b_in_ready !== (q.size() < 2)) begin
        nerr++; $display("FAIL rand_hs cyc %0d: v=%b r=%b want v=%b r=%b", cyc,
                         b_out_valid, b_in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        nvec++; if (b_out_data !== q[0].d || b_out_sel !== q[0].s || b_out_err !== q[0].e) begin
          nerr++; $display("FAIL rand_data cyc %0d: d=%h s=%0d e=%b want d=%h s=%0d e=%b", cyc,
                           b_out_data, b_out_sel, b_out_err, q[0].d, q[0].s, q[0].e);
        end
      end
      b_in_data   = {$urandom, $urandom, $urandom};
      b_sel       = 2'($urandom_range(3));
      b_in_valid  = ($urandom_range(3) != 0);
      b_out_ready = ($urandom_range(3) != 0);
      b_flush     = ($urandom_range(63) == 0);
      do_push = b_in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && b_out_ready;
      e.s = b_sel;
      e.e = (b_sel >= 2'd3);
      e.d = e.e ? RV3 : b_in_data[int'(b_sel)*32 +: 32];
      tick();
      cyc++;
      if (do_pop) pops++;
      if (b_flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end
    b_in_valid = 1'b0; b_flush = 1'b0;
    nvec++; if (pops < 10000) begin
      nerr++; $display("FAIL rand_budget: %0d transfers in %0d cycles, want 10000", pops, cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_sel = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_sel = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_bad_sel();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mux_pipe_reg.md
# mux_pipe_reg

Parametrised registered N:1 selector stage with valid/ready flow control, a 2-entry skid buffer, synchronous flush and out-of-range select detection. It replaces single-purpose registered 2:1 muxes between CPU pipeline stages (PC source, ALU operand and write-back selection) with one block whose width, input count and reset value are configurable. It also supports back-pressure (stall) and bubble insertion (flush).

## Interface

- DATA_W, 32, width of each data channel
- N_IN, 2, number of selectable inputs (2..16)
- SEL_W, $clog2(N_IN), select width, derived, not overridden
- RESET_VAL, 0, value of out_data after reset and for out-of-range selects

Ports:

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  N_IN*DATA_W  packed inputs, channel k at [k*DATA_W +: DATA_W]
- sel  in  SEL_W  channel index, sampled with the transfer
- in_valid  in  1  upstream holds sel/in_data valid
- in_ready  out  1  stage can accept this cycle
- flush  in  1  discard all held entries
- out_data  out  DATA_W  selected data of head entry
- out_sel  out  SEL_W  sel captured with head entry
- out_err  out  1  head entry had sel >= N_IN
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry

## Operation

- Two entries: main (drives outputs) and skid. Each entry holds data, sel, err and a valid bit.
- Upstream transfer: in_valid & in_ready. Captured data is in_data channel sel; if sel >= N_IN, data = RESET_VAL and err = 1.
- Downstream transfer: out_valid & out_ready. This pops main. Skid moves to main in the same edge if it is valid.
- Transfer rules:
  - Push into main when main is empty, or when main pops and skid is empty. Otherwise push into skid.
  - Push with both entries full cannot occur, because in_ready is low.
- in_ready = !skid_valid. It is a pure register output with no combinational path from out_ready.
- Order is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Flush:
  - Next edge clears both valid bits.
  - A push in the same cycle is discarded; flush wins.
  - A pop in the same cycle still counts downstream.
  - out_data/out_sel/out_err keep their last values; only the valid bits clear.
- Reset:
  - Asserting mid-operation immediately clears both entries.
  - out_valid=0, out_data=RESET_VAL, out_sel=0, out_err=0, in_ready=1.
- Invalid entries never change out_data; data registers load only on push.

## Timing

- Latency: 1 cycle from accepted push to out_valid when the stage is empty.
- Throughput: 1 transfer/cycle with out_ready held high; the skid stays empty.
- Stall: out_ready low with main full.
  - The next push goes to skid; in_ready drops the following cycle.
  - At most one extra word is accepted after the stall begins.
- Recovery: when out_ready rises with both entries full:
  - Skid moves to main on that edge.
  - in_ready rises the next cycle.
- in_ready high for one cycle after flush or reset release.
- All outputs are registered; no input-to-output combinational path.

## Structure

- Shared package mux_pipe_pkg holds:
  - default RESET_VAL
  - max N_IN limit (16)
  - entry record typedef (data, sel, err, valid), reused by other pipeline-stage blocks
- One sub-module: mux_n, a combinational N:1 selector returning data and err for an out-of-range index. It is instantiated once, on the input side.
- Top level holds the two entry registers and the push/pop/flush control, about 150–250 lines total.

## Test plan

- Reset, N_IN=4, RESET_VAL=32'hDEAD_BEEF:
  - Assert rst mid-stream with both entries full.
  - Required: out_valid=0 and out_data=32'hDEAD_BEEF immediately; in_ready=1.
- Streaming:
  - out_ready=1; push sel=0..3 with channel k = 32'h1000_0000+k.
  - Required: out_data sequence 10000000,10000001,10000002,10000003, one per cycle, first one cycle after push.
- Stall:
  - Hold out_ready=0 with in_valid=1, data A,B,C.
  - Required: A in main, B in skid, in_ready=0; C is held upstream.
  - Release out_ready: required output order A,B,C with none lost.
- Bad select:
  - N_IN=3, push sel=3.
  - Required: out_err=1, out_sel=3, out_data=RESET_VAL.
  - Following push with sel=1: required out_err=0.
- Flush collision:
  - Both entries full; assert flush with in_valid=1 and out_ready=1 in the same cycle.
  - Required next cycle: out_valid=0, in_ready=1, pushed word never appears, popped word counted once.
- Randomised ready/valid run, 10k transfers, against a scoreboard queue: required zero mismatches and no in_ready→out_ready combinational loop flagged by lint.
